// File: rtl/load_store_unit_pkg.sv
// Shared widths, funct3 access codes, LSU state encoding and request classification helpers.
// Latency: none (declarations only). Backpressure: not applicable.
package load_store_unit_pkg;

   localparam int MEM_ADDR_WIDTH = 8;
   localparam int WORD_BITS      = 32;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;

   typedef enum logic [2:0] {
      LSU_IDLE  = 3'd0,
      LSU_LOAD  = 3'd1,
      LSU_READ  = 3'd2,
      LSU_WRITE = 3'd3,
      LSU_RESP  = 3'd4
   } lsu_state_t;

   function automatic logic req_illegal(input logic we, input logic [2:0] funct3);
      logic bad;
      if (we) begin
         bad = (funct3 > FUNCT3_SW);
      end else begin
         bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      return bad;
   endfunction

   // Access size lives in funct3[1:0] for both loads and stores.
   function automatic logic req_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
      logic bad;
      case (funct3[1:0])
         2'b01:   bad = offset[0];
         2'b10:   bad = (offset != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane extraction with sign/zero extension for loads, lane merge for sub-word stores.
// Latency: purely combinational. Backpressure: none.
module lsu_lane_align
   import load_store_unit_pkg::*;
#(
   parameter int W = WORD_BITS
) (
   input  logic [2:0]   funct3,
   input  logic [1:0]   offset,
   input  logic [W-1:0] word,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] load_data,
   output logic [W-1:0] store_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = word[{offset, 3'b000} +: 8];
   assign half_sel = word[{offset[1], 4'b0000} +: 16];

   always_comb begin
      load_data = '0;
      case (funct3)
         FUNCT3_LB:  load_data = {{(W-8){byte_sel[7]}}, byte_sel};
         FUNCT3_LBU: load_data = {{(W-8){1'b0}}, byte_sel};
         FUNCT3_LH:  load_data = {{(W-16){half_sel[15]}}, half_sel};
         FUNCT3_LHU: load_data = {{(W-16){1'b0}}, half_sel};
         FUNCT3_LW:  load_data = word;
         default:    load_data = '0;
      endcase
   end

   // Unselected lanes keep whatever the read phase fetched from memory.
   always_comb begin
      store_word = word;
      case (funct3)
         FUNCT3_SB: store_word[{offset, 3'b000} +: 8]     = wdata[7:0];
         FUNCT3_SH: store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
         FUNCT3_SW: store_word = wdata;
         default:   store_word = word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, RMW for sub-word stores; LSU_MISALIGN_TRAP_EN enables misalignment errors.
// Latency: error 1, load/SW 2, SB/SH 3 cycles to rsp_valid; rsp held until rsp_ready, req_ready only in IDLE.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
   parameter int WORD_WIDTH = WORD_BITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [WORD_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WORD_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   output logic                  mem_wen,
   output logic [2:0]            mem_type,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WORD_WIDTH-1:0] mem_wd,
   input  logic [WORD_WIDTH-1:0] mem_rd
);

   lsu_state_t state, state_nxt;

   logic [2:0]            funct3_q;
   logic [ADDR_WIDTH+1:0] addr_q;
   logic [WORD_WIDTH-1:0] wdata_q;
   logic [WORD_WIDTH-1:0] merge_q;
   logic [WORD_WIDTH-1:0] rsp_data_q;
   logic                  rsp_err_q;

   logic                  req_misalign;
   logic                  req_err;
   logic                  accept;
   logic [WORD_WIDTH-1:0] align_word;
   logic [WORD_WIDTH-1:0] load_data;
   logic [WORD_WIDTH-1:0] store_word;
   logic                  unused_addr_bits;

   // The word index wraps: high byte-address bits never reach memory.
   assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

`ifdef LSU_MISALIGN_TRAP_EN
   assign req_misalign = req_misaligned(req_funct3, req_addr[1:0]);
`else
   assign req_misalign = 1'b0;
`endif

   assign req_err = req_illegal(req_we, req_funct3) | req_misalign;
   assign accept  = (state == LSU_IDLE) && req_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LSU_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LSU_IDLE: begin
            if (req_valid) begin
               if (req_err) begin
                  state_nxt = LSU_RESP;
               end else if (!req_we) begin
                  state_nxt = LSU_LOAD;
               end else if (req_funct3 == FUNCT3_SW) begin
                  state_nxt = LSU_WRITE;
               end else begin
                  state_nxt = LSU_READ;
               end
            end
         end
         LSU_LOAD:  state_nxt = LSU_RESP;
         LSU_READ:  state_nxt = LSU_WRITE;
         LSU_WRITE: state_nxt = LSU_RESP;
         LSU_RESP: begin
            if (rsp_ready) begin
               state_nxt = LSU_IDLE;
            end
         end
         default:   state_nxt = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         funct3_q   <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         merge_q    <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         if (accept) begin
            funct3_q   <= req_funct3;
            addr_q     <= req_addr[ADDR_WIDTH+1:0];
            wdata_q    <= req_wdata;
            rsp_data_q <= '0;
            rsp_err_q  <= req_err;
         end
         if (state == LSU_LOAD) begin
            rsp_data_q <= load_data;
         end
         if (state == LSU_READ) begin
            merge_q <= mem_rd;
         end
      end
   end

   // Loads extract straight from the memory read port; stores merge into the captured word.
   assign align_word = (state == LSU_LOAD) ? mem_rd : merge_q;

   lsu_lane_align #(
      .W (WORD_WIDTH)
   ) u_lane_align (
      .funct3     (funct3_q),
      .offset     (addr_q[1:0]),
      .word       (align_word),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_word (store_word)
   );

   assign req_ready = (state == LSU_IDLE);
   assign rsp_valid = (state == LSU_RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign mem_wen   = (state == LSU_WRITE);
   assign mem_type  = mem_wen ? FUNCT3_SW : FUNCT3_LW;
   assign mem_addr  = addr_q[ADDR_WIDTH+1:2];
   assign mem_wd    = store_word;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random loads/stores against a memory-level reference model.
// Honours LSU_MISALIGN_TRAP_EN so the same bench covers both builds.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   localparam int AW    = MEM_ADDR_WIDTH;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_we;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr, req_wdata;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [31:0]   rsp_data;
   logic          mem_wen;
   logic [2:0]    mem_type;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wd, mem_rd;

   logic [31:0] mem      [DEPTH];
   logic [31:0] seed_mem [DEPTH];
   logic [31:0] ref_mem  [DEPTH];
   logic        seed_en;
   int          wen_cnt = 0;
   int          checks  = 0;
   int          errors  = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .mem_wen    (mem_wen),
      .mem_type   (mem_type),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   assign mem_rd = mem[mem_addr];

   always @(posedge clk) begin
      if (seed_en) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= seed_mem[i];
      end else if (mem_wen) begin
         mem[mem_addr] <= mem_wd;
         wen_cnt       <= wen_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sext8(input logic [7:0] b);
      return b[7] ? {24'hFF_FFFF, b} : {24'h0, b};
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] h);
      return h[15] ? {16'hFFFF, h} : {16'h0, h};
   endfunction

   // Issue one request, check latency/response/memory effect, then complete the handshake after `hold` stalled cycles.
   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold, output logic [31:0] got);
      int          idx, sh, hs, lat, wr0, exp_lat, exp_wr;
      logic [31:0] old, new_word, exp_data, mask;
      logic        ill, mis, exp_err;

      idx      = int'((addr / 32'd4) % 32'(DEPTH));
      old      = ref_mem[idx];
      new_word = old;
      sh       = 8 * int'(addr % 32'd4);
      hs       = 16 * int'((addr / 32'd2) % 32'd2);
      ill      = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
      mis      = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 32'd2) != 0) mis = 1'b1;
      if (f3 == 3'd2 && (addr % 32'd4) != 0) mis = 1'b1;
`endif
      exp_err  = ill | mis;
      exp_data = 32'h0;
      exp_wr   = 0;
      exp_lat  = 1;
      if (!exp_err && !we) begin
         exp_lat = 2;
         case (f3)
            3'd0:    exp_data = sext8(8'(old >> sh));
            3'd4:    exp_data = {24'h0, 8'(old >> sh)};
            3'd1:    exp_data = sext16(16'(old >> hs));
            3'd5:    exp_data = {16'h0, 16'(old >> hs)};
            default: exp_data = old;
         endcase
      end else if (!exp_err) begin
         exp_wr = 1;
         case (f3)
            3'd0: begin
               mask     = 32'hFF << sh;
               new_word = (old & ~mask) | ((wd & 32'hFF) << sh);
               exp_lat  = 3;
            end
            3'd1: begin
               mask     = 32'hFFFF << hs;
               new_word = (old & ~mask) | ((wd & 32'hFFFF) << hs);
               exp_lat  = 3;
            end
            default: begin
               new_word = wd;
               exp_lat  = 2;
            end
         endcase
      end

      check("req_ready_idle", 32'(req_ready), 32'd1);
      wr0        = wen_cnt;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat       = 1;
      while (rsp_valid !== 1'b1 && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("latency", 32'(lat), 32'(exp_lat));
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
      check("rsp_data", rsp_data, exp_data);
      got = rsp_data;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_req_ready", 32'(req_ready), 32'd0);
         check("hold_data", rsp_data, exp_data);
         check("hold_err", 32'(rsp_err), 32'(exp_err));
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check("rsp_done", 32'(rsp_valid), 32'd0);
      check("write_count", 32'(wen_cnt - wr0), 32'(exp_wr));
      check("mem_word", mem[idx], new_word);
      ref_mem[idx] = new_word;
   endtask

   initial begin
      logic [31:0] got, sh_exp, rnd_addr;
      int          wr0;

      rst_n      = 1'b0;
      seed_en    = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      rsp_ready  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         seed_mem[i] = $urandom;
         ref_mem[i]  = seed_mem[i];
      end
      repeat (3) @(posedge clk);
      #1;
      seed_en = 1'b0;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", rsp_data, 32'h0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_mem_wen", 32'(mem_wen), 32'd0);
      check("rst_mem_type", 32'(mem_type), 32'(FUNCT3_LW));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_req(1'b1, FUNCT3_SW, 32'h10, 32'hDEADBEEF, 0, got);
      run_req(1'b0, FUNCT3_LW, 32'h10, 32'h0, 0, got);
      check("sw_lw_literal", got, 32'hDEADBEEF);
      run_req(1'b1, FUNCT3_SW, 32'h10, 32'h11223344, 1, got);
      run_req(1'b1, FUNCT3_SB, 32'h12, 32'h000000AA, 0, got);
      check("sb_merge_literal", mem[4], 32'h11AA3344);
      run_req(1'b0, FUNCT3_LB, 32'h12, 32'h0, 0, got);
      check("lb_literal", got, 32'hFFFFFFAA);
      run_req(1'b0, FUNCT3_LBU, 32'h12, 32'h0, 0, got);
      check("lbu_literal", got, 32'h000000AA);
      run_req(1'b0, FUNCT3_LH, 32'h11, 32'h0, 0, got);
`ifdef LSU_MISALIGN_TRAP_EN
      check("lh_mis_literal", got, 32'h0);
`else
      check("lh_mis_literal", got, 32'h00003344);
`endif
      run_req(1'b0, 3'b011, 32'h20, 32'h0, 0, got);
      run_req(1'b1, 3'b100, 32'h24, 32'h5555AAAA, 0, got);
      run_req(1'b1, FUNCT3_SW, 32'h16, 32'hCAFEF00D, 0, got);
      run_req(1'b0, FUNCT3_LW, 32'h10, 32'h0, 5, got);

      // Reset while an SH sits in its write cycle.
      sh_exp     = (ref_mem[9] & 32'h0000FFFF) | 32'hBEEF0000;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = FUNCT3_SH;
      req_addr   = 32'h26;
      req_wdata  = 32'h1234BEEF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("sh_wen", 32'(mem_wen), 32'd1);
      check("sh_type", 32'(mem_type), 32'(FUNCT3_SW));
      check("sh_addr", 32'(mem_addr), 32'd9);
      check("sh_wd", mem_wd, sh_exp);
      wr0   = wen_cnt;
      rst_n = 1'b0;
      #1;
      check("midrst_wen", 32'(mem_wen), 32'd0);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd1);
      check("midrst_rsp_data", rsp_data, 32'h0);
      check("midrst_rsp_err", 32'(rsp_err), 32'd0);
      check("midrst_mem_addr", 32'(mem_addr), 32'd0);
      @(posedge clk);
      #1;
      check("midrst_no_write", 32'(wen_cnt - wr0), 32'd0);
      check("midrst_mem_word", mem[9], ref_mem[9]);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int n = 0; n < 200; n++) begin
         rnd_addr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
         run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd_addr,
                 $urandom, $urandom_range(0, 2), got);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
